// File: rtl/match_controller.sv
// Pong match sequencer: gates play, paces serve and post-point pauses in frames,
// keeps both scores and declares the winner.
//
//  state | meaning
//  ------+-----------------------------------------------
//  IDLE  | waiting for the first start key edge
//  SERVE | ball held at centre for SERVE_FRAMES frames
//  PLAY  | rally in progress, motion enabled
//  POINT | post-point pause for POINT_FRAMES frames
//  OVER  | a score reached WIN_SCORE, waiting for restart
module match_controller #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int FRAME_CNT_W  = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               new_frame_i,
    input  logic               start_i,
    input  logic               player_miss_i,
    input  logic               enemy_miss_i,
    output logic               run_o,
    output logic               ball_reset_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] enemy_score_o,
    output logic [2:0]         state_o,
    output logic               game_over_o,
    output logic               winner_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0]     WIN        = SCORE_W'(WIN_SCORE);

    state_t                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SCORE_W-1:0]     player_score_q, player_score_d;
    logic [SCORE_W-1:0]     enemy_score_q, enemy_score_d;
    logic                   start_q;
    logic                   run_q, run_d;
    logic                   ball_reset_q, ball_reset_d;
    logic                   serve_dir_q, serve_dir_d;
    logic                   game_over_q, game_over_d;
    logic                   winner_q, winner_d;

    logic start_edge;
    logic serve_done;
    logic point_done;
    logic win_reached;

    assign start_edge  = start_i & ~start_q;
    assign serve_done  = new_frame_i && (frame_cnt_q == SERVE_LAST);
    assign point_done  = new_frame_i && (frame_cnt_q == POINT_LAST);
    assign win_reached = (player_score_q == WIN) || (enemy_score_q == WIN);

    // start_q resets high so a key held through reset is not seen as an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            frame_cnt_q    <= '0;
            player_score_q <= '0;
            enemy_score_q  <= '0;
            start_q        <= 1'b1;
            run_q          <= 1'b0;
            ball_reset_q   <= 1'b0;
            serve_dir_q    <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            player_score_q <= player_score_d;
            enemy_score_q  <= enemy_score_d;
            start_q        <= start_i;
            run_q          <= run_d;
            ball_reset_q   <= ball_reset_d;
            serve_dir_q    <= serve_dir_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = SERVE;
            SERVE:   if (serve_done) state_d = PLAY;
            PLAY:    if (player_miss_i || enemy_miss_i) state_d = POINT;
            POINT:   if (point_done) state_d = win_reached ? OVER : SERVE;
            OVER:    if (start_edge) state_d = SERVE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops look at state_d so each output lines up with the state it belongs to
    always_comb begin
        player_score_d = player_score_q;
        enemy_score_d  = enemy_score_q;
        serve_dir_d    = serve_dir_q;
        winner_d       = winner_q;
        run_d          = (state_d == PLAY);
        ball_reset_d   = (state_d == SERVE) && (state_q != SERVE);
        game_over_d    = (state_d == OVER);

        if (state_d != state_q)
            frame_cnt_d = '0;
        else if (new_frame_i && (state_q == SERVE || state_q == POINT))
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        else
            frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    player_score_d = '0;
                    enemy_score_d  = '0;
                    serve_dir_d    = 1'b0;
                end
            end
            PLAY: begin
                if (player_miss_i) begin
                    enemy_score_d = enemy_score_q + SCORE_W'(1);
                    serve_dir_d   = 1'b0;
                end else if (enemy_miss_i) begin
                    player_score_d = player_score_q + SCORE_W'(1);
                    serve_dir_d    = 1'b1;
                end
            end
            POINT: begin
                if (point_done && win_reached)
                    winner_d = (player_score_q == WIN);
            end
            OVER: begin
                if (start_edge) begin
                    player_score_d = '0;
                    enemy_score_d  = '0;
                    winner_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign run_o          = run_q;
    assign ball_reset_o   = ball_reset_q;
    assign serve_dir_o    = serve_dir_q;
    assign player_score_o = player_score_q;
    assign enemy_score_o  = enemy_score_q;
    assign state_o        = state_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters; expected
// values are hand-derived from the match rules.
module tb_match_controller;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       new_frame_i = 1'b0;
    logic       start_i = 1'b0;
    logic       player_miss_i = 1'b0;
    logic       enemy_miss_i = 1'b0;
    logic       run_o;
    logic       ball_reset_o;
    logic       serve_dir_o;
    logic [3:0] player_score_o;
    logic [3:0] enemy_score_o;
    logic [2:0] state_o;
    logic       game_over_o;
    logic       winner_o;

    int n_tests = 0;
    int n_fail  = 0;

    match_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .new_frame_i    (new_frame_i),
        .start_i        (start_i),
        .player_miss_i  (player_miss_i),
        .enemy_miss_i   (enemy_miss_i),
        .run_o          (run_o),
        .ball_reset_o   (ball_reset_o),
        .serve_dir_o    (serve_dir_o),
        .player_score_o (player_score_o),
        .enemy_score_o  (enemy_score_o),
        .state_o        (state_o),
        .game_over_o    (game_over_o),
        .winner_o       (winner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic frame_pulse();
        new_frame_i = 1'b1;
        tick();
        new_frame_i = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pulse();
            tick();
        end
    endtask

    // From PLAY: one miss, full point pause, full serve, back in PLAY
    task automatic score_point(input bit player_scores);
        if (player_scores) enemy_miss_i = 1'b1;
        else               player_miss_i = 1'b1;
        tick();
        enemy_miss_i  = 1'b0;
        player_miss_i = 1'b0;
        frames(90);
        frames(60);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_pscore"}, player_score_o, 0);
        check({tag, "_escore"}, enemy_score_o, 0);
        check({tag, "_run"}, run_o, 0);
        check({tag, "_ball_reset"}, ball_reset_o, 0);
        check({tag, "_serve_dir"}, serve_dir_o, 0);
        check({tag, "_game_over"}, game_over_o, 0);
        check({tag, "_winner"}, winner_o, 0);
    endtask

    initial begin
        // 1. reset, start, serve timing
        tick();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();
        player_miss_i = 1'b1;
        enemy_miss_i  = 1'b1;
        tick();
        player_miss_i = 1'b0;
        enemy_miss_i  = 1'b0;
        check("idle_miss_escore", enemy_score_o, 0);
        check("idle_miss_pscore", player_score_o, 0);
        check("idle_miss_state", state_o, 0);
        start_i = 1'b1;
        tick();
        check("start_state", state_o, 1);
        check("start_ball_reset", ball_reset_o, 1);
        tick();
        check("start_ball_reset_drop", ball_reset_o, 0);
        enemy_miss_i = 1'b1;
        tick();
        enemy_miss_i = 1'b0;
        check("serve_miss_pscore", player_score_o, 0);
        frames(59);
        check("serve59_run", run_o, 0);
        check("serve59_state", state_o, 1);
        frame_pulse();
        check("serve60_run", run_o, 1);
        check("serve60_state", state_o, 2);
        tick();
        check("play_run_hold", run_o, 1);

        // 2. enemy miss -> player point, pause, re-serve
        enemy_miss_i = 1'b1;
        tick();
        enemy_miss_i = 1'b0;
        check("emiss_pscore", player_score_o, 1);
        check("emiss_dir", serve_dir_o, 1);
        check("emiss_run", run_o, 0);
        check("emiss_state", state_o, 3);
        player_miss_i = 1'b1;
        tick();
        player_miss_i = 1'b0;
        check("point_miss_escore", enemy_score_o, 0);
        frames(89);
        check("point89_state", state_o, 3);
        frame_pulse();
        check("point90_state", state_o, 1);
        check("point90_ball_reset", ball_reset_o, 1);
        tick();
        check("point90_ball_reset_drop", ball_reset_o, 0);
        frames(60);
        check("reserve_state", state_o, 2);

        // 3. simultaneous misses: player miss wins
        player_miss_i = 1'b1;
        enemy_miss_i  = 1'b1;
        tick();
        player_miss_i = 1'b0;
        enemy_miss_i  = 1'b0;
        check("both_escore", enemy_score_o, 1);
        check("both_pscore", player_score_o, 1);
        check("both_dir", serve_dir_o, 0);
        frames(90);
        frames(60);

        // 4. player reaches 9 and wins
        for (int i = 0; i < 7; i++) score_point(1'b1);
        check("pre_win_pscore", player_score_o, 8);
        check("pre_win_state", state_o, 2);
        enemy_miss_i = 1'b1;
        tick();
        enemy_miss_i = 1'b0;
        check("win_pscore", player_score_o, 9);
        frames(90);
        check("over_state", state_o, 4);
        check("over_game_over", game_over_o, 1);
        check("over_winner", winner_o, 1);
        check("over_run", run_o, 0);
        check("over_pscore", player_score_o, 9);
        check("over_escore", enemy_score_o, 1);
        frames(3);
        check("over_held_key_state", state_o, 4);
        check("over_held_key_pscore", player_score_o, 9);
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        check("restart_state", state_o, 1);
        check("restart_pscore", player_score_o, 0);
        check("restart_escore", enemy_score_o, 0);
        check("restart_game_over", game_over_o, 0);
        check("restart_winner", winner_o, 0);
        check("restart_ball_reset", ball_reset_o, 1);
        frames(60);

        // 6. reset mid-PLAY at 3-2, with start held through reset (5.)
        score_point(1'b1);
        score_point(1'b0);
        score_point(1'b1);
        score_point(1'b0);
        score_point(1'b1);
        check("mid_pscore", player_score_o, 3);
        check("mid_escore", enemy_score_o, 2);
        check("mid_state", state_o, 2);
        rst_i = 1'b1;
        tick();
        check_reset_outputs("midreset");
        rst_i = 1'b0;
        tick();
        tick();
        check("held_start_state", state_o, 0);
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        check("late_start_state", state_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
